// File: rtl/const_func_fifo_pkg.sv
// const_func_fifo_pkg: shared constants and helper functions for the FIFO
package const_func_fifo_pkg;
    `include "const_funcs.vh"
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 5;
endpackage

// File: rtl/const_func_wrap_ctr.sv
// const_func_wrap_ctr: enabled counter that wraps from MAX-1 to 0
module const_func_wrap_ctr import const_func_fifo_pkg::*; #(
    parameter int MAX = 5,
    parameter int AW = clog2(MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [AW-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (en) q <= (q == AW'(MAX - 1)) ? '0 : q + AW'(1);
endmodule

// File: rtl/const_funcs.vh
// const_funcs.vh: elaboration-time helper functions shared between blocks
function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
endfunction

// File: rtl/const_func_fifo.sv
// const_func_fifo: valid/ready FIFO of any depth with a registered head word
module const_func_fifo import const_func_fifo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
    logic             push, pop;

    assign in_ready  = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign rd_nxt    = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);

    const_func_wrap_ctr #(.MAX(DEPTH), .AW(AW)) u_wr (.clk(clk), .rst_n(rst_n), .en(push), .q(wr_ptr));
    const_func_wrap_ctr #(.MAX(DEPTH), .AW(AW)) u_rd (.clk(clk), .rst_n(rst_n), .en(pop), .q(rd_ptr));

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;

    // Head register: next stored word on pop, or the incoming word when the queue is (or goes) empty
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count    <= '0;
            out_data <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (pop && count != CW'(1)) out_data <= mem[rd_nxt];
            else if (push && (count == '0 || pop)) out_data <= in_data;
        end
endmodule
